ahb_bus_arbiter: RTL and testbench

Round-robin AHB arbiter that shares the single AHB slave port of the AHB-to-APB bridge between several AHB masters. It samples per-master bus requests and lock requests, issues a one-hot Hgrant, and drives Hmaster/Hmastlock, which steer the address/control and write-data muxes in front of the bridge. Re-arbitration occurs only at legal AHB transfer boundaries, qualified by the bridge's Hready_out.

---
 rtl/ahb_arb_pkg.sv | 29 ++
 rtl/rr_picker.sv | 36 +++
 rtl/ahb_bus_arbiter.sv | 145 ++++++++++++++
 tb/tb_ahb_bus_arbiter.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/ahb_arb_pkg.sv
// rtl/ahb_arb_pkg.sv - shared Htrans encodings and helpers for the AHB bus arbiter
//
// Purpose: Htrans type and encodings, the maximum supported master count,
//          and a one-hot to index conversion used to locate the granted master.
// Ports:   none (package)

package ahb_arb_pkg;

  typedef logic [1:0] htrans_t;

  localparam htrans_t HTRANS_IDLE   = 2'b00;
  localparam htrans_t HTRANS_BUSY   = 2'b01;
  localparam htrans_t HTRANS_NONSEQ = 2'b10;
  localparam htrans_t HTRANS_SEQ    = 2'b11;

  localparam int MAX_MASTERS = 8;

  // Index of the set bit; the grant vector is kept one-hot, so at most one
  // bit is ever set here.
  function automatic int onehot_to_idx(input logic [MAX_MASTERS-1:0] oh);
    int idx;
    idx = 0;
    for (int i = 0; i < MAX_MASTERS; i++) begin
      if (oh[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// rtl/rr_picker.sv - combinational round-robin request picker
//
// Purpose: searches req from ptr+1 upward, wrapping modulo N, so the master
//          at ptr is considered last.
// Ports:
//   req   in  N      request vector
//   ptr   in  IDX_W  index of the current owner
//   gnt   out N      one-hot winner (all zero when no request)
//   valid out 1      at least one request present

module rr_picker #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic             valid
);

  logic [IDX_W-1:0] idx;

  always_comb begin
    gnt   = '0;
    valid = 1'b0;
    idx   = '0;
    for (int k = 1; k <= N; k++) begin
      idx = IDX_W'((int'(ptr) + k) % N);
      if (!valid && req[idx]) begin
        gnt[idx] = 1'b1;
        valid    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ahb_bus_arbiter.sv
// rtl/ahb_bus_arbiter.sv - round-robin AHB arbiter in front of the AHB-to-APB bridge
//
// Purpose: one-hot registered Hgrant with round-robin rotation at legal AHB
//          transfer boundaries; Hmaster/Hmastlock follow Hgrant on Hready.
// Optional: define ARB_TIMEOUT_EN to force rotation after MAX_BEATS accepted
//           beats of one tenure.
// Ports:
//   Hclk      in  1            bus clock
//   Hreset    in  1            synchronous active-high reset
//   Hbusreq   in  NUM_MASTERS  per-master bus request
//   Hlock     in  NUM_MASTERS  per-master locked-transfer request
//   Htrans    in  2            Htrans of the address-phase owner
//   Hready    in  1            Hready_out from the bridge
//   Hgrant    out NUM_MASTERS  registered one-hot grant
//   Hmaster   out clog2(N)     address-phase owner index
//   Hmastlock out 1            current address phase is locked

module ahb_bus_arbiter
  import ahb_arb_pkg::*;
#(
  parameter int NUM_MASTERS    = 4,
  parameter int DEFAULT_MASTER = 0,
  parameter int MAX_BEATS      = 16
) (
  input  logic                           Hclk,
  input  logic                           Hreset,
  input  logic [NUM_MASTERS-1:0]         Hbusreq,
  input  logic [NUM_MASTERS-1:0]         Hlock,
  input  logic [1:0]                     Htrans,
  input  logic                           Hready,
  output logic [NUM_MASTERS-1:0]         Hgrant,
  output logic [$clog2(NUM_MASTERS)-1:0] Hmaster,
  output logic                           Hmastlock
);

  localparam int IDX_W = $clog2(NUM_MASTERS);
  localparam logic [NUM_MASTERS-1:0] DEF_OH = NUM_MASTERS'(1) << DEFAULT_MASTER;

  if (NUM_MASTERS < 2 || NUM_MASTERS > MAX_MASTERS) begin : g_bad_num_masters
    $error("ahb_bus_arbiter: NUM_MASTERS must be 2..8");
  end
  if (DEFAULT_MASTER < 0 || DEFAULT_MASTER >= NUM_MASTERS) begin : g_bad_default
    $error("ahb_bus_arbiter: DEFAULT_MASTER out of range");
  end
  if (MAX_BEATS < 1) begin : g_bad_max_beats
    $error("ahb_bus_arbiter: MAX_BEATS must be at least 1");
  end

  htrans_t                trans;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]       master_q, master_d;
  logic                   mastlock_q, mastlock_d;
  logic [IDX_W-1:0]       grant_idx;
  logic                   owner_req, owner_lock;
  logic                   timeout_ok, arb_ok;
  logic [NUM_MASTERS-1:0] pick_gnt;
  logic                   pick_valid;

  assign trans = Htrans;

  always_comb begin
    grant_idx  = IDX_W'(onehot_to_idx(MAX_MASTERS'(grant_q)));
    owner_req  = Hbusreq[grant_idx];
    owner_lock = Hlock[grant_idx];
  end

  rr_picker #(
    .N     (NUM_MASTERS),
    .IDX_W (IDX_W)
  ) u_picker (
    .req   (Hbusreq),
    .ptr   (grant_idx),
    .gnt   (pick_gnt),
    .valid (pick_valid)
  );

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(MAX_BEATS + 1);

  logic [CNT_W-1:0] tenure_q, tenure_d;
  logic             others_req;

  // Rotation is forced only at a burst start or idle slot, so a running
  // burst is never cut in the middle.
  always_comb begin
    others_req = |(Hbusreq & ~grant_q);
    timeout_ok = Hready && (tenure_q >= CNT_W'(MAX_BEATS)) &&
                 (trans == HTRANS_IDLE || trans == HTRANS_NONSEQ) &&
                 others_req && !owner_lock;
  end

  always_comb begin
    tenure_d = tenure_q;
    if (grant_d != grant_q) begin
      tenure_d = '0;
    end else if (Hready && trans[1] && tenure_q < CNT_W'(MAX_BEATS)) begin
      tenure_d = tenure_q + 1'b1;
    end
  end

  always_ff @(posedge Hclk) begin
    if (Hreset) tenure_q <= '0;
    else        tenure_q <= tenure_d;
  end
`else
  assign timeout_ok = 1'b0;
`endif

  // A requesting owner keeps the bus until it goes IDLE; a locked requesting
  // owner keeps it regardless of Htrans.
  always_comb begin
    arb_ok = (Hready && !(owner_lock && owner_req) && trans != HTRANS_BUSY &&
              (!owner_req || trans == HTRANS_IDLE)) || timeout_ok;
  end

  always_comb begin
    grant_d    = grant_q;
    master_d   = master_q;
    mastlock_d = mastlock_q;
    if (arb_ok) begin
      grant_d = pick_valid ? pick_gnt : DEF_OH;
    end
    if (Hready) begin
      master_d   = grant_idx;
      mastlock_d = owner_lock;
    end
  end

  always_ff @(posedge Hclk) begin
    if (Hreset) begin
      grant_q    <= DEF_OH;
      master_q   <= IDX_W'(DEFAULT_MASTER);
      mastlock_q <= 1'b0;
    end else begin
      grant_q    <= grant_d;
      master_q   <= master_d;
      mastlock_q <= mastlock_d;
    end
  end

  assign Hgrant    = grant_q;
  assign Hmaster   = master_q;
  assign Hmastlock = mastlock_q;

endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// tb/tb_ahb_bus_arbiter.sv - directed self-checking bench for ahb_bus_arbiter

module tb_ahb_bus_arbiter;

  logic       Hclk = 1'b0;
  logic       Hreset;
  logic [3:0] Hbusreq;
  logic [3:0] Hlock;
  logic [1:0] Htrans;
  logic       Hready;
  logic [3:0] Hgrant;
  logic [1:0] Hmaster;
  logic       Hmastlock;

  int errors = 0;
  int checks = 0;

  localparam logic [1:0] T_IDLE = 2'b00, T_BUSY = 2'b01, T_NONSEQ = 2'b10, T_SEQ = 2'b11;

  ahb_bus_arbiter #(
    .NUM_MASTERS    (4),
    .DEFAULT_MASTER (0),
    .MAX_BEATS      (4)
  ) dut (
    .Hclk      (Hclk),
    .Hreset    (Hreset),
    .Hbusreq   (Hbusreq),
    .Hlock     (Hlock),
    .Htrans    (Htrans),
    .Hready    (Hready),
    .Hgrant    (Hgrant),
    .Hmaster   (Hmaster),
    .Hmastlock (Hmastlock)
  );

  always #5 Hclk = ~Hclk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: inputs were changed at a negedge; this passes one posedge
  // and returns on the following negedge where outputs are sampled.
  task automatic step();
    @(negedge Hclk);
  endtask

  logic [3:0] fair_exp [5];
  logic [3:0] exp_g;

  initial begin
    fair_exp[0] = 4'b0010; fair_exp[1] = 4'b0100; fair_exp[2] = 4'b1000;
    fair_exp[3] = 4'b0001; fair_exp[4] = 4'b0010;

    // Reset
    Hreset = 1'b1; Hbusreq = 4'b0000; Hlock = 4'b0000; Htrans = T_IDLE; Hready = 1'b1;
    step(); step();
    Hreset = 1'b0;
    step();
    chk("reset_grant", 8'(Hgrant), 8'h01);
    chk("reset_master", 8'(Hmaster), 8'h00);
    chk("reset_mastlock", 8'(Hmastlock), 8'h00);

    // Single requester on an idle bus
    Hbusreq = 4'b0100;
    step();
    chk("single_grant_t1", 8'(Hgrant), 8'h04);
    chk("single_master_t1", 8'(Hmaster), 8'h00);
    step();
    chk("single_master_t2", 8'(Hmaster), 8'h02);

    // Fairness: all request, owner alternates NONSEQ then IDLE
    Hreset = 1'b1; Hbusreq = 4'b1111; Htrans = T_NONSEQ;
    step();
    Hreset = 1'b0;
    step();
    chk("fair_start", 8'(Hgrant), 8'h01);
    for (int i = 0; i < 5; i++) begin
      Htrans = T_IDLE;
      step();
      chk($sformatf("fair_rotate%0d", i), 8'(Hgrant), 8'(fair_exp[i]));
      Htrans = T_NONSEQ;
      step();
      chk($sformatf("fair_hold%0d", i), 8'(Hgrant), 8'(fair_exp[i]));
    end
    chk("fair_master", 8'(Hmaster), 8'h01);

    // Wait states freeze grant and master
    Hready = 1'b0; Htrans = T_IDLE;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("wait_grant%0d", i), 8'(Hgrant), 8'h02);
      chk($sformatf("wait_master%0d", i), 8'(Hmaster), 8'h01);
    end
    Hready = 1'b1;
    step();
    chk("wait_release_grant", 8'(Hgrant), 8'h04);
    chk("wait_release_master", 8'(Hmaster), 8'h01);
    Htrans = T_NONSEQ;
    step();
    chk("wait_master_follow", 8'(Hmaster), 8'h02);

    // Lock: master 1 locked and requesting, master 3 waiting
    Hbusreq = 4'b0010; Hlock = 4'b0010; Htrans = T_IDLE;
    step();
    chk("lock_grant_m1", 8'(Hgrant), 8'h02);
    Hbusreq = 4'b1010;
    step();
    chk("lock_hold_idle", 8'(Hgrant), 8'h02);
    chk("lock_master", 8'(Hmaster), 8'h01);
    chk("lock_mastlock", 8'(Hmastlock), 8'h01);
    Htrans = T_NONSEQ;
    step();
    chk("lock_hold_nonseq", 8'(Hgrant), 8'h02);
    chk("lock_mastlock2", 8'(Hmastlock), 8'h01);
    Hlock = 4'b0000; Hbusreq = 4'b1000; Htrans = T_IDLE;
    step();
    chk("lock_release_grant", 8'(Hgrant), 8'h08);
    chk("lock_release_mastlock", 8'(Hmastlock), 8'h00);

    // Long burst from master 0 while master 2 requests
    Hbusreq = 4'b0001; Htrans = T_IDLE;
    step();
    chk("burst_grant_m0", 8'(Hgrant), 8'h01);
    Hbusreq = 4'b0101; Htrans = T_NONSEQ;
    step();
    chk("burst_nonseq", 8'(Hgrant), 8'h01);
    Htrans = T_SEQ;
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("burst_seq%0d", i), 8'(Hgrant), 8'h01);
    end
    Htrans = T_NONSEQ;
    step();
`ifdef ARB_TIMEOUT_EN
    exp_g = 4'b0100;
`else
    exp_g = 4'b0001;
`endif
    chk("burst_next_nonseq", 8'(Hgrant), 8'(exp_g));

    // BUSY blocks arbitration even without an owner request
    Hbusreq = 4'b0100; Htrans = T_BUSY;
    step();
    chk("busy_hold", 8'(Hgrant), 8'(exp_g));
    Htrans = T_IDLE;
    step();
    chk("after_busy_grant", 8'(Hgrant), 8'h04);

    // No requests: park on default master
    Hbusreq = 4'b0000;
    step();
    chk("park_default", 8'(Hgrant), 8'h01);

    // Reset during a wait state
    Hbusreq = 4'b1000;
    step();
    chk("pre_reset_grant", 8'(Hgrant), 8'h08);
    step();
    chk("pre_reset_master", 8'(Hmaster), 8'h03);
    Hready = 1'b0; Hreset = 1'b1;
    step();
    chk("midreset_grant", 8'(Hgrant), 8'h01);
    chk("midreset_master", 8'(Hmaster), 8'h00);
    Hreset = 1'b0; Hready = 1'b1; Hbusreq = 4'b0000;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
